// File: rtl/me_integer.sv
// ---------------------------------------------------------------------------
// me_integer
//   Integer-pel motion estimation over a 2x2 neighbourhood. A 16x16 template
//   is matched against four candidate positions in a 64x64 search window
//   (offsets (dy,dx) = (0,0), (0,1), (1,0), (1,1) from init_pos). The
//   candidate with the smallest sum of absolute differences wins; on a tie
//   the earlier candidate is kept. Window coordinates wrap modulo 64.
//
//   Each candidate takes 258 cycles: 256 RUN cycles (one pixel each), one
//   DRAIN cycle for the last memory return, and one CMP cycle. ack rises
//   1032 edges after the request is accepted.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   synchronous active-low reset
//   req        in   1   start request, level, held until ack seen
//   init_pos   in  12   search origin {y[5:0], x[5:0]}, sampled on accept
//   ack        out  1   result valid, held until req is low
//   min_sad    out 16   minimum SAD of the four candidates
//   min_diff   out  4   winning offset {2'b0 dy, 2'b0 dx} packed as [3:2],[1:0]
//   tmpl_addr  out  8   template address {row, col}, 0 outside RUN
//   tmpl_data  in   8   template pixel, one cycle after tmpl_addr
//   sw_addr    out 12   search-window address {y, x}, 0 outside RUN
//   sw_data    in   8   search-window pixel, one cycle after sw_addr
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for req with ack low
// RUN   | issuing template/window addresses for pixel pix of candidate cand
// DRAIN | last pixel's data returning from memory, accumulated on exit
// CMP   | accumulator complete; fold into running minimum, next candidate
// DONE  | ack high, waiting for req to drop
// ---------------------------------------------------------------------------
module me_integer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [11:0] init_pos,
    output logic        ack,
    output logic [15:0] min_sad,
    output logic [3:0]  min_diff,
    output logic [7:0]  tmpl_addr,
    input  logic [7:0]  tmpl_data,
    output logic [11:0] sw_addr,
    input  logic [7:0]  sw_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_CMP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [11:0] pos_q;
    logic [1:0]  cand;
    logic [7:0]  pix;
    logic [15:0] acc;
    // Set for the cycle in which the data for the previous RUN cycle's
    // address is on the memory outputs.
    logic        acc_vld;
    logic [15:0] best_sad;
    logic [1:0]  best_cand;

    logic        accept;
    logic        cmp_en;
    logic        ack_clr;

    logic [7:0]  abs_diff;
    logic        take_new;
    logic [15:0] win_sad;
    logic [1:0]  win_cand;

    logic [5:0]  sw_y;
    logic [5:0]  sw_x;

    // ------------------------------------------------------------------
    // Next-state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        cmp_en    = 1'b0;
        ack_clr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req && !ack) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (pix == 8'd255) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_nxt = S_CMP;
            end
            S_CMP: begin
                cmp_en    = 1'b1;
                state_nxt = (cand == 2'd3) ? S_DONE : S_RUN;
            end
            S_DONE: begin
                if (!req) begin
                    ack_clr   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address generation: 6-bit sums wrap each coordinate modulo 64.
    // ------------------------------------------------------------------
    always_comb begin
        sw_y = pos_q[11:6] + {5'd0, cand[1]} + {2'd0, pix[7:4]};
        sw_x = pos_q[5:0]  + {5'd0, cand[0]} + {2'd0, pix[3:0]};
        if (state == S_RUN) begin
            tmpl_addr = pix;
            sw_addr   = {sw_y, sw_x};
        end else begin
            tmpl_addr = 8'd0;
            sw_addr   = 12'd0;
        end
    end

    // ------------------------------------------------------------------
    // SAD datapath and minimum selection
    // ------------------------------------------------------------------
    always_comb begin
        if (tmpl_data > sw_data) begin
            abs_diff = tmpl_data - sw_data;
        end else begin
            abs_diff = sw_data - tmpl_data;
        end
        // Strict compare so that ties keep the earlier candidate.
        take_new = (cand == 2'd0) || (acc < best_sad);
        win_sad  = take_new ? acc  : best_sad;
        win_cand = take_new ? cand : best_cand;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pos_q     <= 12'd0;
            cand      <= 2'd0;
            pix       <= 8'd0;
            acc       <= 16'd0;
            acc_vld   <= 1'b0;
            best_sad  <= 16'd0;
            best_cand <= 2'd0;
            ack       <= 1'b0;
            min_sad   <= 16'd0;
            min_diff  <= 4'd0;
        end else begin
            state   <= state_nxt;
            acc_vld <= (state == S_RUN);

            if (accept) begin
                pos_q <= init_pos;
                cand  <= 2'd0;
                pix   <= 8'd0;
                acc   <= 16'd0;
            end else begin
                if (state == S_RUN) begin
                    pix <= pix + 8'd1;
                end
                if (acc_vld) begin
                    acc <= acc + {8'd0, abs_diff};
                end
                if (cmp_en) begin
                    acc       <= 16'd0;
                    pix       <= 8'd0;
                    best_sad  <= win_sad;
                    best_cand <= win_cand;
                    if (cand == 2'd3) begin
                        min_sad  <= win_sad;
                        min_diff <= {1'b0, win_cand[1], 1'b0, win_cand[0]};
                        ack      <= 1'b1;
                    end else begin
                        cand <= cand + 2'd1;
                    end
                end
                if (ack_clr) begin
                    ack <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_me_integer.sv
module tb_me_integer;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [11:0] init_pos;
    logic        ack;
    logic [15:0] min_sad;
    logic [3:0]  min_diff;
    logic [7:0]  tmpl_addr;
    logic [7:0]  tmpl_data;
    logic [11:0] sw_addr;
    logic [7:0]  sw_data;

    logic [7:0]  tmpl_mem [256];
    logic [7:0]  sw_mem   [4096];

    int          errors;
    int          checks;
    logic [15:0] prev_sad;
    logic [3:0]  prev_diff;

    me_integer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .init_pos  (init_pos),
        .ack       (ack),
        .min_sad   (min_sad),
        .min_diff  (min_diff),
        .tmpl_addr (tmpl_addr),
        .tmpl_data (tmpl_data),
        .sw_addr   (sw_addr),
        .sw_data   (sw_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories
    always @(posedge clk) begin
        tmpl_data <= tmpl_mem[tmpl_addr];
        sw_data   <= sw_mem[sw_addr];
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // Reference: exhaustive SAD of the four offsets, strict-less selection.
    task automatic model(input logic [11:0] pos, output int bsad, output logic [3:0] bdiff);
        int y0;
        int x0;
        int s;
        int a;
        int b;
        y0 = int'(pos[11:6]);
        x0 = int'(pos[5:0]);
        bsad = 0;
        bdiff = 4'd0;
        for (int c = 0; c < 4; c++) begin
            s = 0;
            for (int r = 0; r < 16; r++) begin
                for (int q = 0; q < 16; q++) begin
                    a = int'(tmpl_mem[r * 16 + q]);
                    b = int'(sw_mem[((y0 + c / 2 + r) % 64) * 64 + ((x0 + c % 2 + q) % 64)]);
                    s += (a > b) ? a - b : b - a;
                end
            end
            if (c == 0 || s < bsad) begin
                bsad  = s;
                bdiff = 4'((c / 2) * 4 + (c % 2));
            end
        end
    endtask

    task automatic fill_const(input logic [7:0] tv, input logic [7:0] sv);
        for (int i = 0; i < 256; i++) tmpl_mem[i] = tv;
        for (int i = 0; i < 4096; i++) sw_mem[i] = sv;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) tmpl_mem[i] = 8'($urandom);
        for (int i = 0; i < 4096; i++) sw_mem[i] = 8'($urandom);
    endtask

    // One complete transaction, checking addresses every cycle, ack timing,
    // result hold, and the result against the model. Caller is 1ns past an
    // edge with the DUT idle.
    task automatic run_check(input logic [11:0] pos, input bit wiggle, input int hold);
        int          exp_sad;
        logic [3:0]  exp_diff;
        int          c;
        int          k;
        int          et;
        int          esw;
        int          drop_at;
        model(pos, exp_sad, exp_diff);
        drop_at  = int'($urandom_range(1, 1000));
        req      = 1'b1;
        init_pos = pos;
        @(posedge clk);
        #1;
        for (int n = 0; n < 1032; n++) begin
            c = n / 258;
            k = n % 258;
            if (k < 256) begin
                et  = k;
                esw = ((int'(pos[11:6]) + c / 2 + k / 16) % 64) * 64
                    + ((int'(pos[5:0]) + c % 2 + k % 16) % 64);
            end else begin
                et  = 0;
                esw = 0;
            end
            checks++;
            if ({tmpl_addr, sw_addr} !== {8'(et), 12'(esw)}) begin
                errors++;
                $display("FAIL addr n=%0d: tmpl_addr=%0h sw_addr=%0h, required %0h %0h",
                         n, tmpl_addr, sw_addr, et, esw);
            end
            checks++;
            if (ack !== 1'b0 || min_sad !== prev_sad || min_diff !== prev_diff) begin
                errors++;
                $display("FAIL busy_hold n=%0d: ack=%b sad=%0d diff=%b, required 0 %0d %b",
                         n, ack, min_sad, min_diff, prev_sad, prev_diff);
            end
            if (wiggle) begin
                init_pos = 12'($urandom);
                if (n == drop_at) req = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (ack !== 1'b1 || min_sad !== 16'(exp_sad) || min_diff !== exp_diff) begin
            errors++;
            $display("FAIL result pos=%h: ack=%b sad=%0d diff=%b, required 1 %0d %b",
                     pos, ack, min_sad, min_diff, exp_sad, exp_diff);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            checks++;
            if (ack !== 1'b1 || min_sad !== 16'(exp_sad) || min_diff !== exp_diff
                || tmpl_addr !== 8'd0 || sw_addr !== 12'd0) begin
                errors++;
                $display("FAIL ack_hold h=%0d: ack=%b sad=%0d diff=%b, required 1 %0d %b",
                         h, ack, min_sad, min_diff, exp_sad, exp_diff);
            end
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ack !== 1'b0 || min_sad !== 16'(exp_sad) || min_diff !== exp_diff) begin
            errors++;
            $display("FAIL ack_release: ack=%b sad=%0d diff=%b, required 0 %0d %b",
                     ack, min_sad, min_diff, exp_sad, exp_diff);
        end
        prev_sad  = 16'(exp_sad);
        prev_diff = exp_diff;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        req      = 1'b0;
        init_pos = 12'd0;
        fill_const(8'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ack, min_sad, min_diff, tmpl_addr, sw_addr} !== 41'd0) begin
            errors++;
            $display("FAIL reset: ack=%b sad=%0d diff=%b ta=%h sa=%h, required all 0",
                     ack, min_sad, min_diff, tmpl_addr, sw_addr);
        end
        rst_n     = 1'b1;
        prev_sad  = 16'd0;
        prev_diff = 4'd0;
    endtask

    task automatic test_uniform();
        fill_const(8'd10, 8'd10);
        run_check(12'd0, 1'b0, 0);
        checks++;
        if (min_sad !== 16'd0 || min_diff !== 4'b0000) begin
            errors++;
            $display("FAIL uniform: sad=%0d diff=%b, required 0 0000", min_sad, min_diff);
        end
    endtask

    task automatic test_copy();
        fill_random();
        for (int r = 0; r < 16; r++)
            for (int q = 0; q < 16; q++)
                sw_mem[(21 + r) * 64 + 34 + q] = tmpl_mem[r * 16 + q];
        run_check({6'd20, 6'd33}, 1'b0, 0);
        checks++;
        if (min_sad !== 16'd0 || min_diff !== 4'b0101) begin
            errors++;
            $display("FAIL copy: sad=%0d diff=%b, required 0 0101", min_sad, min_diff);
        end
    endtask

    task automatic test_max();
        fill_const(8'd0, 8'd255);
        run_check(12'($urandom), 1'b0, 0);
        checks++;
        if (min_sad !== 16'd65280 || min_diff !== 4'b0000) begin
            errors++;
            $display("FAIL max: sad=%0d diff=%b, required 65280 0000", min_sad, min_diff);
        end
    endtask

    task automatic test_wrap();
        fill_random();
        run_check({6'd63, 6'd63}, 1'b0, 0);
        fill_random();
        run_check({6'd62, 6'd5}, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            fill_random();
            run_check(12'($urandom), 1'b1, 0);
        end
    endtask

    task automatic test_back_to_back();
        fill_random();
        run_check(12'($urandom), 1'b0, 50);
        fill_random();
        run_check(12'($urandom), 1'b0, 0);
    endtask

    task automatic test_reset_midrun();
        fill_random();
        req      = 1'b1;
        init_pos = 12'($urandom);
        @(posedge clk);
        #1;
        repeat (499) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({ack, min_sad, min_diff, tmpl_addr, sw_addr} !== 41'd0) begin
            errors++;
            $display("FAIL reset_midrun: ack=%b sad=%0d diff=%b ta=%h sa=%h, required all 0",
                     ack, min_sad, min_diff, tmpl_addr, sw_addr);
        end
        rst_n     = 1'b1;
        req       = 1'b0;
        prev_sad  = 16'd0;
        prev_diff = 4'd0;
        run_check(12'($urandom), 1'b0, 0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_uniform();
        test_copy();
        test_max();
        test_wrap();
        test_random();
        test_back_to_back();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/me_integer.md
ME_INTEGER -- requirements
Module: me_integer

Interface
REQ-001 Parameters: none; 16x16 template, 64x64 search window, 8-bit unsigned pixels are fixed.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 req  in  1  start request from controller; level, held until ack seen.
REQ-005 init_pos  in  12  search origin, [11:6]=y, [5:0]=x, unsigned; sampled only when accepting req.
REQ-006 ack  out  1  result valid; held high until req is low.
REQ-007 min_sad  out  16  minimum SAD over the 4 candidates.
REQ-008 min_diff  out  4  winning offset, [3:2]=dy, [1:0]=dx, each 2'd0 or 2'd1.
REQ-009 tmpl_addr  out  8  template memory address {row[3:0], col[3:0]}.
REQ-010 tmpl_data  in  8  template pixel, valid one cycle after tmpl_addr (synchronous read).
REQ-011 sw_addr  out  12  search-window address {y[5:0], x[5:0]}.
REQ-012 sw_data  in  8  search-window pixel, valid one cycle after sw_addr.

Function
REQ-013 States: IDLE, RUN, DRAIN, CMP, DONE; any unused encoding SHALL go to IDLE on the next edge.
REQ-014 IDLE: on edge with req=1 and ack=0, latch init_pos, clear candidate counter cand, pixel counter pix and accumulator, go to RUN.
REQ-015 Candidate order: cand 0=(dy0,dx0), 1=(0,1), 2=(1,0), 3=(1,1).
REQ-016 RUN: pix steps 0..255 row-major, one per cycle; after pix=255, go to DRAIN.
REQ-017 tmpl_addr = pix; sw_addr = {(y+dy+row) mod 64, (x+dx+col) mod 64}, 6-bit wrap per coordinate, no saturation.
REQ-018 Outside RUN, tmpl_addr and sw_addr SHALL be 0.
REQ-019 Accumulator adds |tmpl_data - sw_data| (8-bit unsigned absolute difference) on the edge after each RUN cycle; 16-bit, cannot overflow (max 65280).
REQ-020 DRAIN: one cycle for the last memory return; go to CMP.
REQ-021 CMP: cand 0 loads min unconditionally; cand 1..3 replace min only if accumulator < min (strict; ties keep earlier candidate).
REQ-022 CMP with cand<3: cand+1, pix=0, accumulator=0, go to RUN.
REQ-023 CMP with cand=3: update min_sad/min_diff from final min, set ack=1, go to DONE.
REQ-024 Each candidate takes 258 cycles; ack SHALL rise on the 1032nd rising edge after the edge at which req was accepted.
REQ-025 min_sad/min_diff change only on the ack-rising edge; they hold through DONE and IDLE until the next completion.
REQ-026 DONE: on edge with req=0, ack<=0, go to IDLE; a new req is accepted at the earliest on the following edge.
REQ-027 req deassertion during RUN/DRAIN/CMP SHALL be ignored; computation completes and ack rises normally.
REQ-028 init_pos changes after acceptance SHALL not affect the current run.

Reset
REQ-029 rst_n=0 on an edge: state=IDLE, ack=0, min_sad=0, min_diff=0, counters and accumulator=0, in any state including mid-run.
REQ-030 First req after reset release is accepted on the first edge with rst_n=1 and req=1.

Verification
REQ-031 Template all 8'd10, window all 8'd10, init_pos=12'd0 -> ack at edge 1032, min_sad=0, min_diff=4'b0000 (tie keeps cand 0).
REQ-032 Template random, window holds exact copy at origin (21,34), noise elsewhere; init_pos={6'd20,6'd33} -> min_sad=0, min_diff=4'b0101.
REQ-033 Template all 0, window all 255 -> min_sad=16'd65280, min_diff=4'b0000.
REQ-034 init_pos={6'd63,6'd63}: cand 3, pix 0 drives sw_addr=12'h000; cand 0, pix 255 drives sw_addr={6'd14,6'd14}.
REQ-035 req held high 50 cycles past ack -> ack stays 1, outputs stable; req low -> ack 0 next edge; req reasserted -> new run, ack after 1032 edges.
REQ-036 rst_n=0 for one edge at cycle 500 of a run -> ack=0, min_sad=0, min_diff=0, addresses 0; subsequent req completes with correct result.
